// File: rtl/spi_master_mmio.sv
// spi_master_mmio: memory-mapped SPI master, mode 0, MSB first, 8-bit frames.
//
// Ports
//   clk, rst          single clock, asynchronous active-high reset
//   sel, we, re       bus access strobes (region select, store, load)
//   addr[3:0]         byte offset, addr[3:2] picks the register
//   wdata[31:0]       store data
//   rdata[31:0]       combinational load data (0 unless sel&re)
//   sclk, ss, mosi    SPI outputs (ss active-low)
//   miso              SPI input
//   spi_interrupt     done & ie
//   spi_transaction   transfer in progress
//
// Register map
//   0x0 CTRL    bit0 en, bit1 ie, bits[8+DIV_W-1:8] clkdiv
//   0x4 STATUS  bit0 busy (RO), bit1 done (W1C), bit2 ovr (W1C)
//   0x8 TXDATA  write-only byte to send
//   0xC RXDATA  last received byte
//
// FSM states
//   state | meaning
//   IDLE  | ss high, waiting for a TXDATA write with en=1
//   LEAD  | ss low, one half-period of setup before the first sclk rise
//   XFER  | 16 half-periods of sclk, sample on rise, shift on fall
//   TRAIL | ss still low, one half-period of hold after the last sclk fall
module spi_master_mmio #(
  parameter int               DIV_W   = 8,
  parameter logic [DIV_W-1:0] RST_DIV = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sclk,
  output logic        ss,
  output logic        mosi,
  input  logic        miso,
  output logic        spi_interrupt,
  output logic        spi_transaction
);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic             en_q, ie_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] hdiv_q;   // clkdiv frozen for the running transfer
  logic [DIV_W-1:0] cnt_q;    // half-period down-counter, terminal count 0
  logic [3:0]       phase_q;  // half-period index inside XFER
  logic [7:0]       tx_sh_q, rx_sh_q, rx_q;
  logic             done_q, ovr_q, done_d, ovr_d;
  logic             sclk_q, ss_q, mosi_q;

  logic wr, wr_ctrl, wr_stat, wr_tx, busy, start, abort, cnt_tc, done_set, ovr_set;
  logic unused_bits;

  assign wr      = sel & we;
  assign wr_ctrl = wr & (addr[3:2] == 2'd0);
  assign wr_stat = wr & (addr[3:2] == 2'd1);
  assign wr_tx   = wr & (addr[3:2] == 2'd2);
  assign busy    = (state_q != IDLE);
  assign cnt_tc  = (cnt_q == '0);
  assign start   = wr_tx & en_q & ~busy;
  assign abort   = wr_ctrl & ~wdata[0] & busy;
  // TRAIL is still busy, so a TXDATA write on the completing edge is an overrun
  assign ovr_set  = wr_tx & busy;
  assign done_set = (state_q == TRAIL) & cnt_tc & ~abort;

  // Set beats a coincident W1C clear
  assign done_d = done_set | (done_q & ~(wr_stat & wdata[1]));
  assign ovr_d  = ovr_set  | (ovr_q  & ~(wr_stat & wdata[2]));

  assign unused_bits = ^{addr[1:0], wdata};

  always_comb begin
    rdata = '0;
    if (sel && re) begin
      case (addr[3:2])
        2'd0: begin
          rdata[0]          = en_q;
          rdata[1]          = ie_q;
          rdata[8 +: DIV_W] = div_q;
        end
        2'd1:    rdata[2:0] = {ovr_q, done_q, busy};
        2'd3:    rdata[7:0] = rx_q;
        default: rdata      = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      div_q   <= RST_DIV;
      hdiv_q  <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sclk_q  <= 1'b0;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      ovr_q  <= ovr_d;
      if (wr_ctrl) begin
        en_q  <= wdata[0];
        ie_q  <= wdata[1];
        div_q <= wdata[8 +: DIV_W];
      end
      if (abort) begin
        state_q <= IDLE;
        ss_q    <= 1'b1;
        sclk_q  <= 1'b0;
        cnt_q   <= '0;
        phase_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= LEAD;
              ss_q    <= 1'b0;
              mosi_q  <= wdata[7];
              tx_sh_q <= wdata[7:0];
              rx_sh_q <= '0;
              hdiv_q  <= div_q;
              cnt_q   <= div_q;
            end
          end
          LEAD: begin
            if (cnt_tc) begin
              state_q <= XFER;
              sclk_q  <= 1'b1;
              rx_sh_q <= {rx_sh_q[6:0], miso};
              cnt_q   <= hdiv_q;
              phase_q <= '0;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          XFER: begin
            if (cnt_tc) begin
              cnt_q <= hdiv_q;
              if (phase_q == 4'd15) begin
                state_q <= TRAIL;
                sclk_q  <= 1'b0;
              end else begin
                phase_q <= phase_q + 4'd1;
                sclk_q  <= ~sclk_q;
                if (!sclk_q) begin
                  rx_sh_q <= {rx_sh_q[6:0], miso};
                end else if (phase_q != 4'd14) begin
                  // the final falling edge leaves mosi on bit 0
                  mosi_q  <= tx_sh_q[6];
                  tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                end
              end
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          TRAIL: begin
            if (cnt_tc) begin
              state_q <= IDLE;
              ss_q    <= 1'b1;
              rx_q    <= rx_sh_q;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sclk            = sclk_q;
  assign ss              = ss_q;
  assign mosi            = mosi_q;
  assign spi_transaction = busy;
  assign spi_interrupt   = done_q & ie_q;

endmodule

// File: tb/tb_spi_master_mmio.sv
module tb_spi_master_mmio;

  localparam logic [3:0] A_CTRL = 4'h0;
  localparam logic [3:0] A_STAT = 4'h4;
  localparam logic [3:0] A_TX   = 4'h8;
  localparam logic [3:0] A_RX   = 4'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0, we = 1'b0, re = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        sclk, ss, mosi, miso, spi_interrupt, spi_transaction;

  int n_chk = 0;
  int n_err = 0;

  spi_master_mmio #(.DIV_W(8), .RST_DIV(8'h00)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .spi_interrupt(spi_interrupt), .spi_transaction(spi_transaction)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: drives bit 7 while ss falls, advances on each sclk fall
  logic [7:0] slv_byte = 8'h00;
  logic [2:0] slv_idx  = 3'd7;
  always @(negedge sclk or posedge ss) begin
    if (ss) slv_idx = 3'd7;
    else if (slv_idx != 3'd0) slv_idx = slv_idx - 3'd1;
  end
  assign miso = slv_byte[slv_idx];

  // Monitors
  int         cyc = 0;
  int         ss_low = 0;
  int         n_rise = 0;
  int         last_rise = 0, prev_rise = 0;
  logic [7:0] mosi_cap = '0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!ss) ss_low = ss_low + 1;
  end
  always @(posedge sclk) begin
    mosi_cap  = {mosi_cap[6:0], mosi};
    n_rise    = n_rise + 1;
    prev_rise = last_rise;
    last_rise = cyc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; re = 1'b1; addr = a;
    #1;
    d = rdata;
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (!spi_transaction) break;
    end
    if (k == budget) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: timeout after %0d cycles, busy=%b expected 0", name, budget, spi_transaction);
    end
  endtask

  typedef struct {
    logic        do_wr;
    logic [3:0]  waddr;
    logic [31:0] wdat;
    logic [3:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int s_low, s_rise;
    logic [31:0] d;

    vecs[0] = '{1'b1, A_CTRL, 32'h0000_FF03, A_CTRL, 32'h0000_FF03, "ctrl_rw"};
    vecs[1] = '{1'b1, A_CTRL, 32'hFFFF_FFFC, A_CTRL, 32'h0000_FF00, "ctrl_unused"};
    vecs[2] = '{1'b1, A_CTRL, 32'h0000_0502, A_CTRL, 32'h0000_0502, "ctrl_ie_div"};
    vecs[3] = '{1'b1, A_TX,   32'h0000_0055, A_STAT, 32'h0000_0000, "tx_en0_ignored"};
    vecs[4] = '{1'b0, A_TX,   32'h0,         A_TX,   32'h0000_0000, "tx_reads_0"};
    vecs[5] = '{1'b1, A_STAT, 32'h0000_0007, A_STAT, 32'h0000_0000, "stat_ro"};
    vecs[6] = '{1'b1, A_RX,   32'h0000_00FF, A_RX,   32'h0000_0000, "rx_ro"};
    vecs[7] = '{1'b1, A_CTRL, 32'h0000_0000, A_CTRL, 32'h0000_0000, "ctrl_clear"};

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_stat", A_STAT, 32'h0);
    rd_chk("rst_rx",   A_RX,   32'h0);
    check("rst_pins", {28'h0, ss, sclk, mosi, spi_interrupt}, 32'h8);
    check("rst_busy", {31'h0, spi_transaction}, 32'h0);

    // Register table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdat);
      rd_chk(vecs[i].name, vecs[i].raddr, vecs[i].exp);
    end
    wr(A_CTRL, 32'h0000_0003);
    sel = 1'b1; re = 1'b0; addr = A_CTRL; #1;
    check("rdata_no_re", rdata, 32'h0);
    sel = 1'b0;

    // A: clkdiv=0, ie=1, send 0xA5 against slave 0x3C
    slv_byte = 8'h3C;
    s_low = ss_low; s_rise = n_rise;
    wr(A_TX, 32'h0000_00A5);
    check("a_start", {29'h0, ss, spi_transaction, mosi}, 32'h3);
    wait_idle("a_wait", 100);
    check("a_mosi",  {24'h0, mosi_cap}, 32'hA5);
    check("a_rises", n_rise - s_rise, 8);
    check("a_sslow", ss_low - s_low, 18);
    rd_chk("a_rx",   A_RX, 32'h3C);
    rd_chk("a_stat", A_STAT, 32'h2);
    check("a_irq_pins", {29'h0, spi_interrupt, ss, sclk}, 32'h6);
    wr(A_STAT, 32'h2);
    rd_chk("a_clr", A_STAT, 32'h0);

    // B: clkdiv=3, ie=0, send 0xFF
    wr(A_CTRL, 32'h0000_0301);
    slv_byte = 8'hFF;
    s_low = ss_low;
    wr(A_TX, 32'h0000_00FF);
    wait_idle("b_wait", 200);
    check("b_period", last_rise - prev_rise, 8);
    check("b_sslow",  ss_low - s_low, 72);
    check("b_mosi",   {24'h0, mosi_cap}, 32'hFF);
    check("b_irq",    {31'h0, spi_interrupt}, 32'h0);
    rd_chk("b_stat",  A_STAT, 32'h2);
    rd_chk("b_rx",    A_RX, 32'hFF);

    // C: overrun while busy, only the first byte goes out
    wr(A_CTRL, 32'h0000_0103);
    slv_byte = 8'h00;
    s_low = ss_low; s_rise = n_rise;
    wr(A_TX, 32'h0000_0011);
    repeat (3) @(posedge clk);
    #1;
    wr(A_TX, 32'h0000_0022);
    wait_idle("c_wait", 200);
    check("c_mosi",  {24'h0, mosi_cap}, 32'h11);
    check("c_rises", n_rise - s_rise, 8);
    check("c_sslow", ss_low - s_low, 36);
    rd_chk("c_stat", A_STAT, 32'h6);
    wr(A_STAT, 32'h6);
    rd_chk("c_clr",  A_STAT, 32'h0);

    // D: abort by clearing en in the 5th half-period
    wr(A_CTRL, 32'h0000_0003);
    slv_byte = 8'h96;
    wr(A_TX, 32'h0000_005A);
    repeat (5) @(posedge clk);
    #1;
    check("d_busy_before", {31'h0, spi_transaction}, 32'h1);
    wr(A_CTRL, 32'h0);
    check("d_pins", {29'h0, ss, sclk, spi_transaction}, 32'h4);
    rd_chk("d_rx",   A_RX, 32'h00);
    rd_chk("d_stat", A_STAT, 32'h0);

    // F: W1C of done on the very edge done sets
    wr(A_CTRL, 32'h0000_0003);
    wr(A_TX, 32'h0000_0081);
    repeat (17) @(posedge clk);
    #1;
    wr(A_STAT, 32'h2);
    rd_chk("f_done_wins", A_STAT, 32'h2);

    // G: TXDATA write on the completing edge counts as overrun
    wr(A_TX, 32'h0000_0042);
    repeat (17) @(posedge clk);
    #1;
    wr(A_TX, 32'h0000_0077);
    check("g_no_start", {31'h0, spi_transaction}, 32'h0);
    rd_chk("g_ovr", A_STAT, 32'h6);

    // E: asynchronous reset mid-transfer
    wr(A_TX, 32'h0000_00C3);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("e_pins", {28'h0, ss, sclk, mosi, spi_interrupt}, 32'h8);
    check("e_busy", {31'h0, spi_transaction}, 32'h0);
    rd(A_STAT, d);
    check("e_stat", d, 32'h0);
    rd_chk("e_ctrl", A_CTRL, 32'h0);
    rd_chk("e_rx",   A_RX, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // After reset a normal transfer runs
    wr(A_CTRL, 32'h0000_0003);
    slv_byte = 8'h3C;
    wr(A_TX, 32'h0000_00A5);
    wait_idle("r_wait", 100);
    check("r_mosi", {24'h0, mosi_cap}, 32'hA5);
    rd_chk("r_rx",  A_RX, 32'h3C);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_master_mmio.md
SPI_MASTER_MMIO -- requirements
Module: spi_master_mmio

Interface
REQ-001 Parameters SHALL be as follows.
- DIV_W, 8: width of the clock divider field.
- RST_DIV, 0: reset value of the clock divider.
REQ-002 Ports SHALL be as follows (clock and reset first):
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- sel  in  1  memory-stage access targets the SPI region.
- we  in  1  store strobe.
- re  in  1  load strobe.
- addr  in  4  byte offset in the region; addr[3:2] selects the register.
- wdata  in  32  store data.
- rdata  out  32  load data.
- sclk  out  1  SPI clock.
- ss  out  1  slave select, active-low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- spi_interrupt  out  1  level interrupt.
- spi_transaction  out  1  transfer in progress (busy).

Function
REQ-003 The register map SHALL be:
- 0x0 CTRL: bit0 en, bit1 ie, bits[8+DIV_W-1:8] clkdiv.
- 0x4 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 ovr (W1C).
- 0x8 TXDATA: write-only; bits[7:0] are the byte to send.
- 0xC RXDATA: read-only; bits[7:0] are the last received byte.
REQ-004 rdata SHALL be combinational: the selected register when sel&re, 32'h0 otherwise; unused bits read 0; reads of TXDATA SHALL return 0.
REQ-005 A register write SHALL occur on a clk edge with sel&we; writes to read-only fields SHALL be ignored.
REQ-006 The FSM SHALL have the states IDLE, LEAD, XFER and TRAIL; spi_transaction=busy=(state!=IDLE).
REQ-007 IDLE -> LEAD SHALL occur on a TXDATA write with en=1 and busy=0, at the capturing edge:
- ss<=0, mosi<=wdata[7], shift register loaded.
- H=clkdiv+1 latched; clkdiv changes during a transfer SHALL NOT affect that transfer.
REQ-008 A TXDATA write with en=0 SHALL be ignored.
REQ-009 A TXDATA write with busy=1 SHALL be ignored and SHALL set ovr.
REQ-010 Each phase step SHALL last H clk cycles, counted by a half-period counter.
REQ-011 LEAD SHALL last H cycles, then sclk<=1 and the FSM SHALL enter XFER.
REQ-012 XFER SHALL cover 16 half-periods, using SPI mode 0, MSB first, 8 bits:
- On each sclk rising transition, miso SHALL be sampled into the receive shifter.
- On each sclk falling transition except the last, mosi SHALL present the next bit.
REQ-013 After the 16th half-period, sclk SHALL be 0 and the FSM SHALL enter TRAIL for H cycles.
REQ-014 At the end of TRAIL, in one edge: ss<=1, RXDATA<=received byte, done<=1, state<=IDLE.
REQ-015 ss SHALL stay low for exactly 18*H cycles per transfer.
REQ-016 spi_interrupt SHALL equal done&ie.
REQ-017 Clearing en while busy SHALL abort the transfer on that edge:
- ss<=1, sclk<=0, state<=IDLE.
- RXDATA and done SHALL be unchanged.
REQ-018 When a W1C clear of done coincides with done being set, the set SHALL win.
REQ-019 When a W1C clear of ovr coincides with a new overrun, the set SHALL win.
REQ-020 A TXDATA write in the same cycle as the REQ-014 edge SHALL be treated as busy and SHALL set ovr.
REQ-021 A back-to-back transfer SHALL require a TXDATA write in a cycle with busy=0; ss SHALL be high for at least 1 cycle between transfers.
REQ-022 mosi SHALL hold its last value while ss=1; sclk SHALL be 0 whenever ss=1.

Reset
REQ-023 rst=1 SHALL force the following immediately, regardless of clk, including mid-transfer:
- state=IDLE.
- CTRL=0 with clkdiv=RST_DIV.
- done=ovr=0, RXDATA=0.
- sclk=0, ss=1, mosi=0.
- spi_interrupt=0, spi_transaction=0.
- half-period counter and shifters cleared.
REQ-024 After rst deasserts, the first TXDATA write with en=1 SHALL start a normal transfer.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- CTRL=0x0003 (clkdiv=0), TXDATA=0xA5, miso driven by a slave returning 0x3C -> mosi bits 1,0,1,0,0,1,0,1; ss low 18 cycles; RXDATA=0x3C; done=1; spi_interrupt=1.
- CTRL=0x0301 (clkdiv=3, ie=0), TXDATA=0xFF -> sclk period 8 cycles, ss low 72 cycles, spi_interrupt stays 0, STATUS=0x2.
- TXDATA=0x11, then TXDATA=0x22 while busy -> ovr=1; only 0x11 is sent; writing STATUS=0x6 clears done and ovr.
- Write CTRL=0 in the 5th half-period -> ss=1 and sclk=0 next cycle; RXDATA unchanged; done=0.
- Assert rst mid-transfer, asynchronously between edges -> ss=1, sclk=0, rdata of STATUS=0 without waiting for clk.
- W1C of done on the same edge done sets -> done reads 1.
